// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock-waveform monitor.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      HIGH,
      LOW
   } state_t;

   localparam int unsigned ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/clk_edge_det.sv
// Two-stage sampler of the monitored waveform with rise/fall detection.
module clk_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   output logic rise_c,
   output logic fall_c
);

   logic s_q;
   logic p_q;

   // Sample the waveform and keep one cycle of history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= 1'b0;
         p_q <= 1'b0;
      end else begin
         s_q <= clk_in;
         p_q <= s_q;
      end
   end

   assign rise_c = s_q & ~p_q;
   assign fall_c = ~s_q & p_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low phase lengths of a sampled waveform, checks them against
// expected durations, reports lock and counts errors.
// Optional build macro CLK_MON_TOL_EN: accept phases within +/-TOL cycles.
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W        = 6,
   parameter int unsigned LOCK_PERIODS = 2,
   parameter int unsigned TOL          = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clk_in,
   input  logic [CNT_W-1:0]     exp_high,
   input  logic [CNT_W-1:0]     exp_low,
   output logic                 locked,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0]     meas_high,
   output logic [CNT_W-1:0]     meas_low
);

   localparam int unsigned DIFF_W = CNT_W + 1;
   localparam int unsigned GOOD_W = $clog2(LOCK_PERIODS + 1);
   localparam logic [CNT_W-1:0]  RUN_MAX  = '1;
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_PERIODS);
`ifdef CLK_MON_TOL_EN
   localparam int unsigned TOL_EFF = TOL;
`else
   // Exact match only: tolerance forced to zero.
   localparam int unsigned TOL_EFF = TOL * 0;
`endif

   logic rise_c;
   logic fall_c;

   logic [CNT_W-1:0]     run_cnt;
   state_t               state, state_d;
   logic [GOOD_W-1:0]    good_cnt, good_d;
   logic                 high_ok, high_ok_d;
   logic                 locked_d;
   logic                 err_d;
   logic [ERR_CNT_W-1:0] err_cnt_d;
   logic [CNT_W-1:0]     meas_high_d;
   logic [CNT_W-1:0]     meas_low_d;

   clk_edge_det u_edge (
      .clk    (clk),
      .rst    (rst),
      .clk_in (clk_in),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   // Compare at one extra bit so the absolute difference never wraps.
   function automatic logic phase_ok(input logic [CNT_W-1:0] meas,
                                     input logic [CNT_W-1:0] expv);
      logic [DIFF_W-1:0] a;
      logic [DIFF_W-1:0] b;
      logic [DIFF_W-1:0] diff;
      a    = {1'b0, meas};
      b    = {1'b0, expv};
      diff = (a >= b) ? (a - b) : (b - a);
      return diff <= DIFF_W'(TOL_EFF);
   endfunction

   // Phase length counter: restarts at 1 on every edge, saturates at max.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt <= '0;
      end else if (rise_c || fall_c) begin
         run_cnt <= CNT_W'(1);
      end else if (run_cnt != RUN_MAX) begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

   // State and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         good_cnt  <= '0;
         high_ok   <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
         meas_high <= '0;
         meas_low  <= '0;
      end else begin
         state     <= state_d;
         good_cnt  <= good_d;
         high_ok   <= high_ok_d;
         locked    <= locked_d;
         err       <= err_d;
         err_cnt   <= err_cnt_d;
         meas_high <= meas_high_d;
         meas_low  <= meas_low_d;
      end
   end

   // Next-state, measurement capture, lock tracking and error counting.
   always_comb begin
      state_d     = state;
      good_d      = good_cnt;
      high_ok_d   = high_ok;
      locked_d    = locked;
      err_d       = 1'b0;
      err_cnt_d   = err_cnt;
      meas_high_d = meas_high;
      meas_low_d  = meas_low;

      if (!en) begin
         state_d   = IDLE;
         locked_d  = 1'b0;
         good_d    = '0;
         high_ok_d = 1'b0;
      end else begin
         case (state)
            IDLE: state_d = SYNC;
            SYNC: begin
               if (rise_c) state_d = HIGH;
            end
            HIGH: begin
               if (fall_c) begin
                  meas_high_d = run_cnt;
                  state_d     = LOW;
                  if (phase_ok(run_cnt, exp_high)) begin
                     high_ok_d = 1'b1;
                  end else begin
                     err_d     = 1'b1;
                     good_d    = '0;
                     locked_d  = 1'b0;
                     high_ok_d = 1'b0;
                  end
               end else if (run_cnt == RUN_MAX) begin
                  err_d     = 1'b1;
                  good_d    = '0;
                  locked_d  = 1'b0;
                  high_ok_d = 1'b0;
                  state_d   = SYNC;
               end
            end
            LOW: begin
               if (rise_c) begin
                  meas_low_d = run_cnt;
                  state_d    = HIGH;
                  high_ok_d  = 1'b0;
                  if (!phase_ok(run_cnt, exp_low)) begin
                     err_d    = 1'b1;
                     good_d   = '0;
                     locked_d = 1'b0;
                  end else if (high_ok) begin
                     // A full period is good only if its high phase was good too.
                     if (good_cnt != GOOD_MAX) good_d = good_cnt + GOOD_W'(1);
                     if (good_d == GOOD_MAX) locked_d = 1'b1;
                  end
               end else if (run_cnt == RUN_MAX) begin
                  err_d     = 1'b1;
                  good_d    = '0;
                  locked_d  = 1'b0;
                  high_ok_d = 1'b0;
                  state_d   = SYNC;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (err_d && (err_cnt != ERR_CNT_MAX)) err_cnt_d = err_cnt + ERR_CNT_W'(1);
   end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor.
module tb_clk_div_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       clk_in;
   logic [5:0] exp_high;
   logic [5:0] exp_low;
   logic       locked;
   logic       err;
   logic [7:0] err_cnt;
   logic [5:0] meas_high;
   logic [5:0] meas_low;

   int checks     = 0;
   int failures   = 0;
   int err_pulses = 0;

   clk_div_monitor #(.CNT_W(6), .LOCK_PERIODS(2), .TOL(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clk_in    (clk_in),
      .exp_high  (exp_high),
      .exp_low   (exp_low),
      .locked    (locked),
      .err       (err),
      .err_cnt   (err_cnt),
      .meas_high (meas_high),
      .meas_low  (meas_low)
   );

   always #5 clk = ~clk;

   // Count err pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (err === 1'b1) err_pulses <= err_pulses + 1;
   end

   // Present a level for n clk samples; returns 1 time unit after the last edge.
   task automatic hold(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         clk_in = lvl;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; clk_in = 1'b0; exp_high = 6'd5; exp_low = 6'd5;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0d want=0", locked); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0d want=0", err); end
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
      checks++; if (meas_high !== 6'd0) begin failures++; $display("FAIL reset_meas_high got=%0d want=0", meas_high); end
      checks++; if (meas_low !== 6'd0) begin failures++; $display("FAIL reset_meas_low got=%0d want=0", meas_low); end
   endtask

   task automatic test_lock();
      en = 1'b1;
      hold(1'b0, 6);
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 5); hold(1'b0, 5);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0d want=0", locked); end
      hold(1'b1, 2);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%0d want=1", locked); end
      checks++; if (meas_high !== 6'd5) begin failures++; $display("FAIL lock_meas_high got=%0d want=5", meas_high); end
      checks++; if (meas_low !== 6'd5) begin failures++; $display("FAIL lock_meas_low got=%0d want=5", meas_low); end
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL lock_err_cnt got=%0d want=0", err_cnt); end
      checks++; if (err_pulses !== 0) begin failures++; $display("FAIL lock_err_pulses got=%0d want=0", err_pulses); end
      hold(1'b1, 3); hold(1'b0, 5);
   endtask

   task automatic test_mismatch();
      hold(1'b1, 6);
      hold(1'b0, 2);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL mis_err got=%0d want=1", err); end
      checks++; if (meas_high !== 6'd6) begin failures++; $display("FAIL mis_meas_high got=%0d want=6", meas_high); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mis_locked got=%0d want=0", locked); end
      checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL mis_err_cnt got=%0d want=1", err_cnt); end
      hold(1'b0, 3);
      checks++; if (err_pulses !== 1) begin failures++; $display("FAIL mis_single_pulse got=%0d want=1", err_pulses); end
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 5); hold(1'b0, 5);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mis_relock_early got=%0d want=0", locked); end
      hold(1'b1, 2);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mis_relock got=%0d want=1", locked); end
      hold(1'b1, 3); hold(1'b0, 5);
   endtask

   task automatic test_timeout();
      hold(1'b1, 64);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_early got=%0d want=0", err); end
      hold(1'b1, 1);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%0d want=1", err); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL to_locked got=%0d want=0", locked); end
      hold(1'b1, 5);
      checks++; if (meas_high !== 6'd5) begin failures++; $display("FAIL to_meas_high got=%0d want=5", meas_high); end
      checks++; if (meas_low !== 6'd5) begin failures++; $display("FAIL to_meas_low got=%0d want=5", meas_low); end
      checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL to_err_cnt got=%0d want=2", err_cnt); end
      checks++; if (err_pulses !== 2) begin failures++; $display("FAIL to_err_pulses got=%0d want=2", err_pulses); end
      hold(1'b0, 5);
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 2);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL to_relock got=%0d want=1", locked); end
      hold(1'b1, 3); hold(1'b0, 3);
   endtask

   task automatic test_rst_mid();
      pulse_rst();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0d want=0", locked); end
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
      checks++; if (meas_high !== 6'd0) begin failures++; $display("FAIL rst_meas_high got=%0d want=0", meas_high); end
      checks++; if (meas_low !== 6'd0) begin failures++; $display("FAIL rst_meas_low got=%0d want=0", meas_low); end
      hold(1'b0, 2);
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 5); hold(1'b0, 5);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_relock_early got=%0d want=0", locked); end
      hold(1'b1, 2);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rst_relock got=%0d want=1", locked); end
      hold(1'b1, 3); hold(1'b0, 5);
   endtask

   task automatic test_saturate();
      int base;
      base = err_pulses;
      exp_high = 6'd0;
      for (int p = 0; p < 100; p++) begin hold(1'b1, 5); hold(1'b0, 5); end
      checks++; if (err_cnt !== 8'd100) begin failures++; $display("FAIL sat_err_cnt_100 got=%0d want=100", err_cnt); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sat_locked got=%0d want=0", locked); end
      for (int p = 0; p < 200; p++) begin hold(1'b1, 5); hold(1'b0, 5); end
      checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got=%0d want=255", err_cnt); end
      checks++; if ((err_pulses - base) !== 300) begin failures++; $display("FAIL sat_pulses got=%0d want=300", err_pulses - base); end
      exp_high = 6'd5;
   endtask

   task automatic test_tol();
      logic [7:0] e1, e2, e3;
`ifdef CLK_MON_TOL_EN
      e1 = 8'd0; e2 = 8'd1; e3 = 8'd1;
`else
      e1 = 8'd1; e2 = 8'd2; e3 = 8'd3;
`endif
      pulse_rst();
      hold(1'b0, 4);
      hold(1'b1, 6); hold(1'b0, 5);
      checks++; if (err_cnt !== e1) begin failures++; $display("FAIL tol_h6_err_cnt got=%0d want=%0d", err_cnt, e1); end
      checks++; if (meas_high !== 6'd6) begin failures++; $display("FAIL tol_h6_meas got=%0d want=6", meas_high); end
      hold(1'b1, 7); hold(1'b0, 5);
      checks++; if (err_cnt !== e2) begin failures++; $display("FAIL tol_h7_err_cnt got=%0d want=%0d", err_cnt, e2); end
      checks++; if (meas_high !== 6'd7) begin failures++; $display("FAIL tol_h7_meas got=%0d want=7", meas_high); end
      hold(1'b1, 4); hold(1'b0, 5);
      checks++; if (err_cnt !== e3) begin failures++; $display("FAIL tol_h4_err_cnt got=%0d want=%0d", err_cnt, e3); end
      checks++; if (meas_high !== 6'd4) begin failures++; $display("FAIL tol_h4_meas got=%0d want=4", meas_high); end
      checks++; if (meas_low !== 6'd5) begin failures++; $display("FAIL tol_meas_low got=%0d want=5", meas_low); end
   endtask

   task automatic test_enable();
      int base;
      pulse_rst();
      hold(1'b0, 3);
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 5); hold(1'b0, 5);
      hold(1'b1, 2);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL en_locked got=%0d want=1", locked); end
      hold(1'b1, 1);
      base = err_pulses;
      en = 1'b0;
      hold(1'b1, 1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL en_off_locked got=%0d want=0", locked); end
      hold(1'b1, 70); hold(1'b0, 5);
      checks++; if ((err_pulses - base) !== 0) begin failures++; $display("FAIL en_off_pulses got=%0d want=0", err_pulses - base); end
      checks++; if (meas_high !== 6'd5) begin failures++; $display("FAIL en_off_meas_high got=%0d want=5", meas_high); end
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL en_off_err_cnt got=%0d want=0", err_cnt); end
      en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_mismatch();
      test_timeout();
      test_rst_mid();
      test_saturate();
      test_tol();
      test_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
